see_output_monitor: RTL and testbench



---
 rtl/see_output_monitor.sv | 136 +++++++++++++
 tb/tb_see_output_monitor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/see_output_monitor.sv
// Campaign monitor for golden vs fault-injected outputs. Registers each result
// beat, compares it in a second stage and accumulates saturating mismatch statistics.

module see_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    cnt <= '0;
        else if (clr)               cnt <= '0;
        else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
    end
endmodule

module see_output_monitor #(
    parameter int OUT_W = 5,
    parameter int IDX_W = 9,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [IDX_W:0]         vec_count,
    input  logic                   in_valid,
    input  logic [IDX_W-1:0]       vec_idx,
    input  logic [OUT_W-1:0]       golden_o,
    input  logic [OUT_W-1:0]       faulty_o,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [OUT_W-1:0]       bit_err_flags,
    output logic [OUT_W*CNT_W-1:0] bit_err_cnt,
    output logic                   first_err_valid,
    output logic [IDX_W-1:0]       first_err_idx
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [OUT_W-1:0] golden;
        logic [OUT_W-1:0] faulty;
    } beat_t;

    state_t         state, state_n;
    logic [IDX_W:0] remaining;
    logic           clr, accept;
    beat_t          s1_beat;
    logic           s1_vld;
    logic [OUT_W-1:0] mis;
    logic           mis_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE: if (start) begin
                clr     = 1'b1;
                state_n = (vec_count == '0) ? FLUSH : RUN;
            end
            RUN: if (in_valid) begin
                accept = 1'b1;
                if (remaining == 1) state_n = FLUSH;
            end
            FLUSH:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FLUSH);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         remaining <= '0;
        else if (clr)    remaining <= vec_count;
        else if (accept) remaining <= remaining - 1'b1;
    end

    // Stage 1: capture the accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_beat <= '0;
        end else if (clr) begin
            s1_vld  <= 1'b0;
            s1_beat <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) s1_beat <= '{idx: vec_idx, golden: golden_o, faulty: faulty_o};
        end
    end

    // Stage 2: compare and accumulate; runs in any state so FLUSH drains the last beat
    assign mis     = s1_vld ? (s1_beat.golden ^ s1_beat.faulty) : '0;
    assign mis_any = |mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_err_flags   <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else if (clr) begin
            bit_err_flags   <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
        end else begin
            bit_err_flags <= bit_err_flags | mis;
            if (mis_any && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= s1_beat.idx;
            end
        end
    end

    see_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk(clk), .rst(rst), .clr(clr), .inc(mis_any), .cnt(err_cnt)
    );

    for (genvar k = 0; k < OUT_W; k++) begin : g_lane
        see_sat_cnt #(.CNT_W(CNT_W)) u_bit_cnt (
            .clk(clk), .rst(rst), .clr(clr), .inc(mis[k]),
            .cnt(bit_err_cnt[k*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_see_output_monitor.sv
// Directed campaigns against a full-width and a 4-bit-counter instance; expected
// statistics are queued at stimulus time and checked on each done pulse.

module tb_see_output_monitor;
    localparam int OUT_W = 5, IDX_W = 9, CNT_W = 16, SAT_W = 4;

    typedef struct packed {
        logic [15:0]           err;
        logic [4:0]            flags;
        logic [4:0][15:0]      bits;
        logic                  fev;
        logic [8:0]            fidx;
        logic [31:0]           dcyc;
    } exp_t;

    logic clk = 0, rst = 1, start = 0, in_valid = 0;
    logic [IDX_W:0]   vec_count = '0;
    logic [IDX_W-1:0] vec_idx = '0;
    logic [OUT_W-1:0] golden_o = '0, faulty_o = '0;

    logic busy, done, fev, s_busy, s_done, s_fev;
    logic [CNT_W-1:0] err_cnt;
    logic [SAT_W-1:0] s_err_cnt;
    logic [OUT_W-1:0] flags, s_flags;
    logic [OUT_W*CNT_W-1:0] bits;
    logic [OUT_W*SAT_W-1:0] s_bits;
    logic [IDX_W-1:0] fidx, s_fidx;

    int n_cmp = 0, n_err = 0, cyc = 0;
    exp_t sb_q[$];

    logic [8:0] b_idx[32];
    logic [4:0] b_g[32], b_f[32];
    bit         b_gap[32], b_start[32];

    see_output_monitor #(.OUT_W(OUT_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .vec_count(vec_count), .in_valid(in_valid),
        .vec_idx(vec_idx), .golden_o(golden_o), .faulty_o(faulty_o), .busy(busy), .done(done),
        .err_cnt(err_cnt), .bit_err_flags(flags), .bit_err_cnt(bits),
        .first_err_valid(fev), .first_err_idx(fidx));

    see_output_monitor #(.OUT_W(OUT_W), .IDX_W(IDX_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .vec_count(vec_count), .in_valid(in_valid),
        .vec_idx(vec_idx), .golden_o(golden_o), .faulty_o(faulty_o), .busy(s_busy), .done(s_done),
        .err_cnt(s_err_cnt), .bit_err_flags(s_flags), .bit_err_cnt(s_bits),
        .first_err_valid(s_fev), .first_err_idx(s_fidx));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat4(input logic [15:0] v);
        return (v > 16'd15) ? 32'd15 : {16'd0, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_flags"}, flags, 0);
        chk({tag, "_bits_lo"}, bits[31:0], 0);
        chk({tag, "_bits_hi"}, {12'd0, bits[79:64]} | {16'd0, bits[63:48]} | bits[47:32], 0);
        chk({tag, "_fev"}, fev, 0);
        chk({tag, "_fidx"}, fidx, 0);
    endtask

    // Scoreboard: every done pulse must match the oldest queued campaign
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_cycle", cyc, e.dcyc);
                chk("err_cnt", err_cnt, e.err);
                chk("flags", flags, e.flags);
                chk("fev", fev, e.fev);
                chk("fidx", fidx, e.fidx);
                for (int k = 0; k < OUT_W; k++) begin
                    chk($sformatf("bit_cnt%0d", k), bits[k*CNT_W +: CNT_W], e.bits[k]);
                    chk($sformatf("sat_bit_cnt%0d", k), s_bits[k*SAT_W +: SAT_W], sat4(e.bits[k]));
                end
                chk("sat_done", s_done, 1);
                chk("sat_err_cnt", s_err_cnt, sat4(e.err));
                chk("sat_flags", s_flags, e.flags);
                chk("sat_fev", s_fev, e.fev);
                chk("sat_fidx", s_fidx, e.fidx);
            end
        end
    end

    task automatic campaign(input int cnt, input int nb);
        exp_t e;
        logic [4:0] m;
        e = '0;
        start = 1; vec_count = cnt[IDX_W:0];
        if (cnt == 0) begin e.dcyc = cyc + 2; sb_q.push_back(e); end
        step();
        start = 0;
        chk("busy_run", busy, 1);
        chk("sat_busy_run", s_busy, 1);
        for (int i = 0; i < nb; i++) begin
            if (b_gap[i]) begin in_valid = 0; step(); end
            in_valid = 1; vec_idx = b_idx[i]; golden_o = b_g[i]; faulty_o = b_f[i];
            start = b_start[i]; vec_count = 1;
            if (i < cnt) begin
                m = b_g[i] ^ b_f[i];
                e.flags |= m;
                for (int k = 0; k < OUT_W; k++) e.bits[k] += {15'd0, m[k]};
                if (m != 0) begin
                    e.err++;
                    if (!e.fev) begin e.fev = 1; e.fidx = b_idx[i]; end
                end
                if (i == cnt - 1) begin e.dcyc = cyc + 2; sb_q.push_back(e); end
            end
            step();
        end
        in_valid = 0; start = 0;
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) step();
        if (sb_q.size() > 0) begin
            chk("done_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic clear_beats();
        for (int i = 0; i < 32; i++) begin
            b_idx[i] = i[8:0]; b_g[i] = 0; b_f[i] = 0; b_gap[i] = 0; b_start[i] = 0;
        end
    endtask

    initial begin
        #3;
        chk_zero("reset");
        @(negedge clk); rst = 0;
        step(); step();
        chk("busy_after_rst", busy, 0);

        // all matching
        clear_beats();
        for (int i = 0; i < 4; i++) begin b_g[i] = 5'h0A; b_f[i] = 5'h0A; end
        campaign(4, 4);

        // mixed mismatches
        clear_beats();
        b_idx[0] = 5; b_g[0] = 5'b00100; b_f[0] = 5'b00000;
        b_idx[1] = 6; b_g[1] = 5'b01010; b_f[1] = 5'b01010;
        b_idx[2] = 7; b_g[2] = 5'b10001; b_f[2] = 5'b00000;
        campaign(3, 3);

        // saturation on the narrow instance
        clear_beats();
        for (int i = 0; i < 20; i++) begin b_g[i] = 5'h1F; b_f[i] = 5'h00; end
        campaign(20, 20);

        // empty campaign
        clear_beats();
        campaign(0, 0);

        // gaps and extra beats
        clear_beats();
        b_idx[0] = 10; b_g[0] = 5'h01; b_gap[0] = 1;
        b_idx[1] = 11; b_g[1] = 5'h02; b_gap[1] = 1;
        b_idx[2] = 12; b_g[2] = 5'h1F;
        b_idx[3] = 13; b_g[3] = 5'h1F; b_gap[3] = 1;
        b_idx[4] = 14; b_g[4] = 5'h10;
        campaign(2, 5);

        // start pulsed mid-run is ignored
        clear_beats();
        b_g[1] = 5'h08; b_start[1] = 1;
        b_g[2] = 5'h06; b_f[2] = 5'h02; b_start[2] = 1;
        b_g[4] = 5'h01; b_f[4] = 5'h10;
        campaign(5, 5);

        // asynchronous abort after 2 of 5 beats
        start = 1; vec_count = 5; step(); start = 0;
        in_valid = 1; golden_o = 5'h1F; faulty_o = 0; vec_idx = 1; step();
        vec_idx = 2; step();
        in_valid = 0;
        step();
        #2 rst = 1;
        #1 chk_zero("abort");
        step(); step();
        rst = 0;
        for (int i = 0; i < 6; i++) step();
        chk("busy_after_abort", busy, 0);
        chk("abort_err_cnt", err_cnt, 0);

        // campaign after abort
        clear_beats();
        b_idx[0] = 3; b_g[0] = 5'h04; b_f[0] = 5'h05;
        b_idx[1] = 9; b_g[1] = 5'h1E; b_f[1] = 5'h1E;
        campaign(2, 2);

        step();
        chk("q_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
